// File: rtl/note_tone_player.sv
// -----------------------------------------------------------------------------
// note_tone_player
//   Plays the notes a melody sequencer hands over. Each note is a tone
//   half-period (Freq_in) and a duration (Temp_in), both in Clk_in cycles.
//   The block latches a note, drives a square wave for its duration, and
//   drops Duracao for exactly one cycle to ask the sequencer for the next one.
//
// Ports
//   Clk_in      system clock
//   Reset_n     asynchronous active-low reset
//   Play_in     play request (level)
//   Stop_in     stop request (level), wins over Play_in
//   Disparo_in  sequencer output-valid; Freq_in/Temp_in sampled only when 1
//   Freq_in     tone half-period in cycles, 0 = rest
//   Temp_in     note duration in cycles, 0 behaves as 1
//   Duracao     1 = note in progress / hold, 0 = advance sequencer
//   Tone_out    square-wave audio output
//   Nota_fim    one-cycle pulse in the last cycle of each note
//   Playing     1 while the player is busy with a melody (GAP/LATCH/PLAY)
// -----------------------------------------------------------------------------
module note_tone_player #(
   parameter int   W         = 28,
   parameter logic TONE_IDLE = 1'b0
) (
   input  logic         Clk_in,
   input  logic         Reset_n,
   input  logic         Play_in,
   input  logic         Stop_in,
   input  logic         Disparo_in,
   input  logic [W-1:0] Freq_in,
   input  logic [W-1:0] Temp_in,
   output logic         Duracao,
   output logic         Tone_out,
   output logic         Nota_fim,
   output logic         Playing
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_LATCH,
      S_PLAY
   } state_t;

   state_t       state;
   state_t       state_nx;

   logic [W-1:0] freq_q;
   logic [W-1:0] temp_q;
   logic [W-1:0] dur_cnt;
   logic [W-1:0] half_cnt;
   logic [W-1:0] dur_last;
   logic [W-1:0] half_last;
   logic         tone_q;
   logic         note_end;
   logic         half_wrap;

   // A zero duration is a one-cycle note, so its last count is 0 as well.
   assign dur_last  = (temp_q == '0) ? '0 : temp_q - W'(1);
   assign half_last = freq_q - W'(1);

   assign note_end  = (state == S_PLAY) && (dur_cnt == dur_last);
   // Only meaningful for a sounding note; a rest never wraps.
   assign half_wrap = (freq_q != '0) && (half_cnt == half_last);

   // ---------------------------------------------------------------- FSM
   // NOTE: state_nx gets a default before any branch so every path assigns
   //       it and no latch is inferred.
   always_comb begin
      state_nx = state;
      if (Stop_in) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (Play_in)    state_nx = S_GAP;
            S_GAP:                   state_nx = S_LATCH;
            S_LATCH: if (Disparo_in) state_nx = S_PLAY;
            S_PLAY:  if (note_end)   state_nx = Play_in ? S_GAP : S_IDLE;
            default:                 state_nx = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk_in or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge Clk_in or negedge Reset_n) begin
      if (!Reset_n) begin
         freq_q   <= '0;
         temp_q   <= '0;
         dur_cnt  <= '0;
         half_cnt <= '0;
         tone_q   <= TONE_IDLE;
      end else if (Stop_in) begin
         dur_cnt  <= '0;
         half_cnt <= '0;
         tone_q   <= TONE_IDLE;
      end else begin
         case (state)
            S_LATCH: begin
               if (Disparo_in) begin
                  freq_q <= Freq_in;
                  temp_q <= Temp_in;
               end
               dur_cnt  <= '0;
               half_cnt <= '0;
               tone_q   <= TONE_IDLE;
            end
            S_PLAY: begin
               if (note_end) begin
                  // Leaving PLAY: silence the output and park the counters.
                  dur_cnt  <= '0;
                  half_cnt <= '0;
                  tone_q   <= TONE_IDLE;
               end else begin
                  dur_cnt <= dur_cnt + W'(1);
                  if (freq_q == '0) begin
                     half_cnt <= '0;
                     tone_q   <= TONE_IDLE;
                  end else if (half_wrap) begin
                     half_cnt <= '0;
                     tone_q   <= ~tone_q;
                  end else begin
                     half_cnt <= half_cnt + W'(1);
                  end
               end
            end
            default: begin
               dur_cnt  <= '0;
               half_cnt <= '0;
               tone_q   <= TONE_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   // All outputs decode registered state only, so they are glitch-free
   // with respect to the level inputs.
   assign Duracao  = (state != S_GAP);
   assign Playing  = (state != S_IDLE);
   assign Nota_fim = note_end;
   assign Tone_out = tone_q;

endmodule

// File: tb/tb_note_tone_player.sv
// -----------------------------------------------------------------------------
// tb_note_tone_player
//   Self-checking bench for note_tone_player. A sequencer model answers each
//   Duracao=0 cycle by presenting a note (directed plan or random), and pushes
//   the note it presented onto a scoreboard queue. A monitor watches the DUT
//   outputs, pops the note when PLAY begins and compares the whole note
//   (tone waveform, length, end pulse, following GAP/IDLE) against values
//   computed from the note parameters with plain arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_note_tone_player;

   localparam int   W         = 28;
   localparam logic TONE_IDLE = 1'b0;

   logic         Clk_in = 1'b0;
   logic         Reset_n;
   logic         Play_in;
   logic         Stop_in;
   logic         Disparo_in;
   logic [W-1:0] Freq_in;
   logic [W-1:0] Temp_in;
   logic         Duracao;
   logic         Tone_out;
   logic         Nota_fim;
   logic         Playing;

   always #5 Clk_in = ~Clk_in;

   note_tone_player #(.W(W), .TONE_IDLE(TONE_IDLE)) dut (
      .Clk_in     (Clk_in),
      .Reset_n    (Reset_n),
      .Play_in    (Play_in),
      .Stop_in    (Stop_in),
      .Disparo_in (Disparo_in),
      .Freq_in    (Freq_in),
      .Temp_in    (Temp_in),
      .Duracao    (Duracao),
      .Tone_out   (Tone_out),
      .Nota_fim   (Nota_fim),
      .Playing    (Playing)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input longint actual, input longint expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   typedef struct packed { int f; int t; int d; } plan_t;
   typedef struct packed { int f; int t; } note_t;

   plan_t plan_q[$];   // notes the sequencer model will present next
   note_t exp_q[$];    // scoreboard: notes actually presented to the DUT

   // ------------------------------------------------ sequencer model
   initial begin
      plan_t p;
      forever begin
         @(negedge Clk_in);
         if (Reset_n && !Duracao) begin
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else begin
               p.f = int'($urandom_range(0, 6));
               p.t = int'($urandom_range(0, 14));
               p.d = int'($urandom_range(0, 2));
            end
            @(posedge Clk_in); #2;
            for (int i = 0; i < p.d && Playing && Reset_n; i++) begin
               @(posedge Clk_in); #2;
            end
            if (Reset_n && Playing && Duracao) begin
               Disparo_in = 1'b1;
               Freq_in    = W'(p.f);
               Temp_in    = W'(p.t);
               exp_q.push_back('{f: p.f, t: p.t});
               @(posedge Clk_in); #2;
               Disparo_in = 1'b0;
               Freq_in    = W'($urandom);
               Temp_in    = W'($urandom);
            end
         end
      end
   end

   // ------------------------------------------------ monitor / scoreboard
   bit    in_note    = 0;
   bit    start_next = 0;
   bit    prev_dur   = 1;
   int    after_chk  = 0;   // 1: expect GAP next cycle, 2: expect IDLE next cycle
   int    k;
   int    tone_err;
   int    exp_len;
   int    notes_done = 0;
   note_t cur;
   logic  exp_tone;

   always @(negedge Clk_in) begin
      if (!Reset_n) begin
         in_note    = 0;
         start_next = 0;
         prev_dur   = 1;
         after_chk  = 0;
         exp_q.delete();
      end else begin
         if (after_chk == 1)
            check("gap_after_note", Duracao, 0);
         else if (after_chk == 2)
            check("idle_after_note", {Playing, Duracao, Tone_out}, {1'b0, 1'b1, TONE_IDLE});
         after_chk = 0;

         if (!Duracao) check("single_gap_cycle", prev_dur, 1);
         prev_dur = Duracao;

         if (start_next) begin
            in_note    = 1;
            start_next = 0;
            k          = 0;
            tone_err   = 0;
         end

         if (in_note) begin
            k++;
            exp_len = (cur.t == 0) ? 1 : cur.t;
            if (cur.f == 0) exp_tone = TONE_IDLE;
            else            exp_tone = TONE_IDLE ^ ((((k - 1) / cur.f) % 2) == 1);
            if (Tone_out !== exp_tone) tone_err++;
            if (k == exp_len) begin
               check("note_tone_wave", tone_err, 0);
               check("note_end_pulse", Nota_fim, 1);
               notes_done++;
               in_note   = 0;
               after_chk = (Play_in && !Stop_in) ? 1 : 2;
               if (Stop_in) exp_q.delete();
            end else if (Nota_fim) begin
               check("note_length", k, exp_len);
               notes_done++;
               in_note   = 0;
               after_chk = (Play_in && !Stop_in) ? 1 : 2;
            end else if (Stop_in) begin
               in_note   = 0;
               after_chk = 2;
               exp_q.delete();
            end
         end else begin
            check("silent_outputs", {Tone_out, Nota_fim}, {TONE_IDLE, 1'b0});
            if (Stop_in) begin
               after_chk = 2;
               exp_q.delete();
            end else if (Playing && Duracao && Disparo_in) begin
               if (exp_q.size() == 0) check("scoreboard_nonempty", 0, 1);
               else begin
                  cur        = exp_q.pop_front();
                  start_next = 1;
               end
            end
         end
      end
   end

   // ------------------------------------------------ bounded waits
   task automatic wait_in_note(input int budget);
      int n = 0;
      do begin
         @(posedge Clk_in); #2;
         n++;
      end while (!in_note && n < budget);
      if (!in_note) check("timeout_note_start", 0, 1);
   endtask

   task automatic wait_notes(input int target, input int budget);
      int n = 0;
      while (notes_done < target && n < budget) begin
         @(posedge Clk_in); #2;
         n++;
      end
      if (notes_done < target) check("timeout_notes", notes_done, target);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(posedge Clk_in); #2;
         n++;
      end while (Playing && n < budget);
      if (Playing) check("timeout_idle", 1, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------ main sequence
   int base;
   int nrand;

   initial begin
      Reset_n    = 1'b0;
      Play_in    = 1'b0;
      Stop_in    = 1'b0;
      Disparo_in = 1'b0;
      Freq_in    = '0;
      Temp_in    = '0;
      repeat (2) @(posedge Clk_in);
      #2;
      check("rst_duracao",  Duracao,  1);
      check("rst_tone",     Tone_out, TONE_IDLE);
      check("rst_nota_fim", Nota_fim, 0);
      check("rst_playing",  Playing,  0);
      Reset_n = 1'b1;
      repeat (3) @(posedge Clk_in);
      #2;
      check("idle_after_reset", {Playing, Duracao}, {1'b0, 1'b1});

      // Single note F=3 T=12, Play dropped mid-note: note finishes, no GAP.
      base = notes_done;
      plan_q.push_back('{f: 3, t: 12, d: 0});
      Play_in = 1'b1;
      wait_in_note(50);
      Play_in = 1'b0;
      wait_idle(100);
      check("single_note_count", notes_done - base, 1);

      // Back-to-back notes.
      base = notes_done;
      plan_q.push_back('{f: 2, t: 8,  d: 0});
      plan_q.push_back('{f: 5, t: 10, d: 0});
      Play_in = 1'b1;
      wait_notes(base + 2, 200);
      Play_in = 1'b0;
      wait_idle(100);

      // Rest, zero duration, fastest tone.
      base = notes_done;
      plan_q.push_back('{f: 0, t: 6, d: 0});
      plan_q.push_back('{f: 0, t: 0, d: 1});
      plan_q.push_back('{f: 1, t: 7, d: 0});
      Play_in = 1'b1;
      wait_notes(base + 3, 200);
      Play_in = 1'b0;
      wait_idle(100);

      // Sequencer late by 4 cycles in LATCH.
      base = notes_done;
      plan_q.push_back('{f: 4, t: 9, d: 4});
      Play_in = 1'b1;
      wait_in_note(50);
      Play_in = 1'b0;
      wait_idle(100);
      check("latch_wait_note_count", notes_done - base, 1);

      // Stop in the same cycle as Nota_fim.
      base = notes_done;
      plan_q.push_back('{f: 3, t: 5, d: 0});
      Play_in = 1'b1;
      wait_in_note(50);
      for (int n = 0; n < 50 && !Nota_fim; n++) begin
         @(posedge Clk_in); #2;
      end
      check("nota_fim_seen", Nota_fim, 1);
      Stop_in = 1'b1;
      Play_in = 1'b0;
      @(posedge Clk_in); #2;
      Stop_in = 1'b0;
      check("stop_end_count", notes_done - base, 1);
      repeat (2) @(posedge Clk_in);
      #2;
      check("stop_stays_idle", {Playing, Duracao}, {1'b0, 1'b1});

      // Random melodies ended by Play drop or by Stop mid-note.
      for (int r = 0; r < 8; r++) begin
         base    = notes_done;
         nrand   = int'($urandom_range(2, 5));
         Play_in = 1'b1;
         wait_notes(base + nrand, 400);
         if (r % 2 == 0) begin
            Play_in = 1'b0;
         end else begin
            wait_in_note(50);
            repeat ($urandom_range(0, 2)) @(posedge Clk_in);
            #2;
            Stop_in = 1'b1;
            Play_in = 1'b0;
            @(posedge Clk_in); #2;
            Stop_in = 1'b0;
         end
         wait_idle(100);
      end

      // Asynchronous reset in the middle of a sounding note.
      plan_q.push_back('{f: 3, t: 20, d: 0});
      Play_in = 1'b1;
      wait_in_note(50);
      repeat (3) @(posedge Clk_in);
      #3;
      check("pre_reset_tone", Tone_out, 1);
      Reset_n = 1'b0;
      Play_in = 1'b0;
      #1;
      check("async_rst_duracao", Duracao,  1);
      check("async_rst_tone",    Tone_out, TONE_IDLE);
      check("async_rst_playing", Playing,  0);
      check("async_rst_fim",     Nota_fim, 0);
      repeat (2) @(negedge Clk_in);
      @(posedge Clk_in); #2;
      Reset_n = 1'b1;
      repeat (4) @(posedge Clk_in);
      #2;
      check("post_reset_idle", {Playing, Duracao, Tone_out}, {1'b0, 1'b1, TONE_IDLE});
      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
